// File: rtl/ikbd_tx_arbiter.sv
// IKBD transmit arbiter: grants one of keyboard/mouse/joystick a whole packet
// towards the SCI transmitter. Define IKBD_ARB_ROUND_ROBIN_EN for round robin.
module ikbd_tx_arbiter #(
    parameter int MAXLEN = 8
) (
    input  logic       CLKx2,
    input  logic       RSTn,
    input  logic [2:0] REQ,
    input  logic [7:0] DAT0,
    input  logic [7:0] DAT1,
    input  logic [7:0] DAT2,
    input  logic [2:0] LAST,
    output logic [2:0] NXT,
    output logic [2:0] GNT,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    input  logic       TX_READY,
    output logic       BUSY,
    output logic       ERR
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [3:0] CNT_MAX = 4'(MAXLEN - 1);

    logic [0:0] state;
    logic [3:0] cnt;
    logic [1:0] ptr;
    logic [2:0] winner;
    logic [1:0] g_idx;
    logic       req_g;
    logic       last_g;
    logic       xfer;
    logic       at_max;

`ifdef IKBD_ARB_ROUND_ROBIN_EN
    // Round robin: search starts just after the last winner
    always_comb begin
        winner = 3'b000;
        case (ptr)
            2'd0: begin
                if (REQ[1])      winner = 3'b010;
                else if (REQ[2]) winner = 3'b100;
                else if (REQ[0]) winner = 3'b001;
            end
            2'd1: begin
                if (REQ[2])      winner = 3'b100;
                else if (REQ[0]) winner = 3'b001;
                else if (REQ[1]) winner = 3'b010;
            end
            default: begin
                if (REQ[0])      winner = 3'b001;
                else if (REQ[1]) winner = 3'b010;
                else if (REQ[2]) winner = 3'b100;
            end
        endcase
    end
`else
    // Fixed priority: keyboard over mouse over joystick
    always_comb begin
        winner = 3'b000;
        if (REQ[0])      winner = 3'b001;
        else if (REQ[1]) winner = 3'b010;
        else if (REQ[2]) winner = 3'b100;
    end

    // The last-winner pointer is kept for observability only
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    // Index of the current grant, used to record the last winner
    always_comb begin
        g_idx = 2'd0;
        if (GNT[1])      g_idx = 2'd1;
        else if (GNT[2]) g_idx = 2'd2;
    end

    assign req_g  = |(REQ & GNT);
    assign last_g = |(LAST & GNT);
    assign at_max = (cnt == CNT_MAX);
    assign xfer   = (state == S_SEND) & TX_VALID & TX_READY & req_g;
    assign NXT    = xfer ? GNT : 3'b000;

    // Route the granted requester's byte to the transmitter
    always_comb begin
        TX_DATA = 8'h00;
        if (GNT[0])      TX_DATA = DAT0;
        else if (GNT[1]) TX_DATA = DAT1;
        else if (GNT[2]) TX_DATA = DAT2;
    end

    // Grant state machine, byte counter and last-winner pointer
    always_ff @(posedge CLKx2 or negedge RSTn) begin
        if (!RSTn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            ptr      <= 2'd2;
            GNT      <= 3'b000;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            ERR <= 1'b0;
            if (state == S_IDLE) begin
                if (|REQ) begin
                    GNT      <= winner;
                    TX_VALID <= 1'b1;
                    BUSY     <= 1'b1;
                    cnt      <= 4'd0;
                    state    <= S_SEND;
                end
            end else begin
                if (!req_g) begin
                    // Requester withdrew mid-packet: abandon it
                    state    <= S_IDLE;
                    GNT      <= 3'b000;
                    TX_VALID <= 1'b0;
                    BUSY     <= 1'b0;
                    ptr      <= g_idx;
                    ERR      <= 1'b1;
                end else if (xfer) begin
                    cnt <= cnt + 4'd1;
                    if (last_g || at_max) begin
                        state    <= S_IDLE;
                        GNT      <= 3'b000;
                        TX_VALID <= 1'b0;
                        BUSY     <= 1'b0;
                        ptr      <= g_idx;
                        ERR      <= ~last_g;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ikbd_tx_arbiter.sv
// Scoreboard bench for ikbd_tx_arbiter (MAXLEN=4).
// Stimulus pushes expected transfers; a monitor pops them on each NXT pulse.
module tb_ikbd_tx_arbiter;

    logic       CLKx2;
    logic       RSTn;
    logic [2:0] REQ;
    logic [7:0] DAT0, DAT1, DAT2;
    logic [2:0] LAST;
    logic [2:0] NXT;
    logic [2:0] GNT;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic       BUSY;
    logic       ERR;

    ikbd_tx_arbiter #(.MAXLEN(4)) dut (
        .CLKx2(CLKx2), .RSTn(RSTn), .REQ(REQ),
        .DAT0(DAT0), .DAT1(DAT1), .DAT2(DAT2),
        .LAST(LAST), .NXT(NXT), .GNT(GNT),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .BUSY(BUSY), .ERR(ERR)
    );

    initial CLKx2 = 1'b0;
    always #5 CLKx2 = ~CLKx2;

    typedef struct {
        logic [2:0] nxt;
        logic [7:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t e_mon;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_exp = 0;

    logic [7:0] pk[3][16];
    int         len[3];
    bit         lst_en[3];
    bit         rep[3];
    int         idx[3];
    logic [2:0] reqv;
    logic [2:0] nxt_s;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    task automatic push(input logic [2:0] n, input logic [7:0] d);
        exp_t e;
        e.nxt  = n;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic load(input int r, input int n, input bit le, input bit rp);
        len[r]    = n;
        lst_en[r] = le;
        rep[r]    = rp;
        idx[r]    = 0;
    endtask

    task automatic drive();
        REQ  = reqv;
        DAT0 = pk[0][idx[0]];
        DAT1 = pk[1][idx[1]];
        DAT2 = pk[2][idx[2]];
        for (int r = 0; r < 3; r++)
            LAST[r] = lst_en[r] && (idx[r] == len[r] - 1);
    endtask

    // One clock: requesters advance on consumed bytes, end at next negedge
    task automatic cyc();
        #2;
        nxt_s = NXT;
        @(posedge CLKx2);
        #1;
        for (int r = 0; r < 3; r++) begin
            if (nxt_s[r]) begin
                if (lst_en[r] && idx[r] == len[r] - 1) begin
                    idx[r] = 0;
                    if (!rep[r]) reqv[r] = 1'b0;
                end else begin
                    idx[r] = idx[r] + 1;
                end
            end
        end
        drive();
        @(negedge CLKx2);
    endtask

    // Monitor: every consumed byte must match the scoreboard head
    always @(negedge CLKx2) begin
        #2;
        if (RSTn) begin
            if (ERR) begin
                err_seen++;
                checks++;
                if (NXT !== 3'b000) begin
                    errors++;
                    $display("FAIL err_with_nxt got nxt=%b want 000", NXT);
                end
            end
            if (NXT !== 3'b000) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL nxt_unexpected got nxt=%b data=%h want none",
                             NXT, TX_DATA);
                end else begin
                    e_mon = sbq.pop_front();
                    if (NXT !== e_mon.nxt || TX_DATA !== e_mon.data) begin
                        errors++;
                        $display("FAIL xfer got nxt=%b data=%h want nxt=%b data=%h",
                                 NXT, TX_DATA, e_mon.nxt, e_mon.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) pk[r][i] = 8'h00;
            load(r, 1, 1'b1, 1'b0);
        end
        reqv     = 3'b000;
        TX_READY = 1'b1;
        RSTn     = 1'b0;
        drive();

        // Reset state
        repeat (2) @(negedge CLKx2);
        chk("rst_gnt", {5'b0, GNT}, 8'h00);
        chk("rst_valid", {7'b0, TX_VALID}, 8'h00);
        chk("rst_busy", {7'b0, BUSY}, 8'h00);
        chk("rst_err", {7'b0, ERR}, 8'h00);
        chk("rst_nxt", {5'b0, NXT}, 8'h00);
        chk("rst_data", TX_DATA, 8'h00);
        RSTn = 1'b1;

        // Single keyboard byte
        pk[0][0] = 8'h1C;
        load(0, 1, 1'b1, 1'b0);
        push(3'b001, 8'h1C);
        reqv = 3'b001;
        drive();
        cyc();
        chk("kb_gnt", {5'b0, GNT}, 8'h01);
        chk("kb_valid", {7'b0, TX_VALID}, 8'h01);
        chk("kb_busy", {7'b0, BUSY}, 8'h01);
        chk("kb_data", TX_DATA, 8'h1C);
        cyc();
        chk("kb_idle_gnt", {5'b0, GNT}, 8'h00);
        chk("kb_idle_valid", {7'b0, TX_VALID}, 8'h00);
        chk("kb_idle_busy", {7'b0, BUSY}, 8'h00);
        chk("kb_idle_err", {7'b0, ERR}, 8'h00);

        // Mouse packet with transmitter back-pressure
        pk[1][0] = 8'hF8;
        pk[1][1] = 8'h05;
        pk[1][2] = 8'hFB;
        load(1, 3, 1'b1, 1'b0);
        push(3'b010, 8'hF8);
        push(3'b010, 8'h05);
        push(3'b010, 8'hFB);
        reqv     = 3'b010;
        TX_READY = 1'b0;
        drive();
        cyc();
        for (int k = 0; k < 3; k++) begin
            repeat (4) begin
                chk("ms_hold_valid", {7'b0, TX_VALID}, 8'h01);
                chk("ms_hold_data", TX_DATA, pk[1][k]);
                cyc();
            end
            TX_READY = 1'b1;
            cyc();
            TX_READY = 1'b0;
        end
        chk("ms_busy_end", {7'b0, BUSY}, 8'h00);
        TX_READY = 1'b1;

        // All requesting, one-byte packets, fresh pointer
        RSTn = 1'b0;
        cyc();
        RSTn = 1'b1;
        pk[0][0] = 8'hA0;
        pk[1][0] = 8'hB1;
        pk[2][0] = 8'hC2;
        for (int r = 0; r < 3; r++) load(r, 1, 1'b1, 1'b1);
`ifdef IKBD_ARB_ROUND_ROBIN_EN
        push(3'b001, 8'hA0);
        push(3'b010, 8'hB1);
        push(3'b100, 8'hC2);
        push(3'b001, 8'hA0);
`else
        repeat (4) push(3'b001, 8'hA0);
`endif
        reqv = 3'b111;
        drive();
        for (int i = 1; i <= 7; i++) begin
            cyc();
            chk("arb_gap_busy", {7'b0, BUSY}, (i % 2 == 1) ? 8'h01 : 8'h00);
        end
        cyc();
        for (int r = 0; r < 3; r++) rep[r] = 1'b0;
        reqv = 3'b000;
        drive();
        cyc();
        chk("arb_stop_busy", {7'b0, BUSY}, 8'h00);

        // Joystick never sends LAST: truncated at 4 bytes
        for (int i = 0; i < 16; i++) pk[2][i] = 8'h10 + 8'(i);
        load(2, 16, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(3'b100, 8'h10 + 8'(i));
        err_exp++;
        reqv = 3'b100;
        drive();
        repeat (4) cyc();
        cyc();
        chk("trunc_err", {7'b0, ERR}, 8'h01);
        chk("trunc_busy", {7'b0, BUSY}, 8'h00);
        reqv = 3'b000;
        drive();
        cyc();
        chk("trunc_err_once", {7'b0, ERR}, 8'h00);

        // Mouse withdraws after one byte, keyboard waiting
        pk[1][0] = 8'h31;
        pk[1][1] = 8'h32;
        pk[1][2] = 8'h33;
        load(1, 3, 1'b1, 1'b0);
        pk[0][0] = 8'h44;
        load(0, 1, 1'b1, 1'b0);
        push(3'b010, 8'h31);
        push(3'b001, 8'h44);
        err_exp++;
        reqv = 3'b010;
        drive();
        cyc();
        reqv[0] = 1'b1;
        drive();
        cyc();
        chk("abort_gnt_held", {5'b0, GNT}, 8'h02);
        reqv[1] = 1'b0;
        drive();
        #1;
        chk("abort_nxt", {5'b0, NXT}, 8'h00);
        cyc();
        chk("abort_err", {7'b0, ERR}, 8'h01);
        chk("abort_gnt", {5'b0, GNT}, 8'h00);
        chk("abort_busy", {7'b0, BUSY}, 8'h00);
        cyc();
        chk("pend_gnt", {5'b0, GNT}, 8'h01);
        cyc();
        chk("pend_busy", {7'b0, BUSY}, 8'h00);

        // Reset mid-packet, then a full 4-byte packet from scratch
        pk[0][0] = 8'h51;
        pk[0][1] = 8'h52;
        pk[0][2] = 8'h53;
        load(0, 3, 1'b1, 1'b0);
        push(3'b001, 8'h51);
        reqv = 3'b001;
        drive();
        cyc();
        cyc();
        TX_READY = 1'b0;
        drive();
        #1;
        RSTn = 1'b0;
        #1;
        chk("arst_gnt", {5'b0, GNT}, 8'h00);
        chk("arst_valid", {7'b0, TX_VALID}, 8'h00);
        chk("arst_nxt", {5'b0, NXT}, 8'h00);
        chk("arst_busy", {7'b0, BUSY}, 8'h00);
        chk("arst_data", TX_DATA, 8'h00);
        for (int i = 0; i < 4; i++) begin
            pk[0][i] = 8'h61 + 8'(i);
            push(3'b001, 8'h61 + 8'(i));
        end
        load(0, 4, 1'b1, 1'b0);
        TX_READY = 1'b1;
        drive();
        cyc();
        RSTn = 1'b1;
        cyc();
        chk("post_rst_gnt", {5'b0, GNT}, 8'h01);
        chk("post_rst_data", TX_DATA, 8'h61);
        repeat (3) cyc();
        cyc();
        chk("post_rst_busy", {7'b0, BUSY}, 8'h00);
        chk("post_rst_err", {7'b0, ERR}, 8'h00);
        cyc();

        chk("sb_empty", 8'(sbq.size()), 8'h00);
        chk("err_count", 8'(err_seen), 8'(err_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
